// File: rtl/ysyx_24100006_icache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24100006_icache_pkg : shared types, AXI constants, geometry     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package ysyx_24100006_icache_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOOKUP  = 3'd1,
      S_MISS_AR = 3'd2,
      S_MISS_R  = 3'd3,
      S_RESP    = 3'd4,
      S_FLUSH   = 3'd5
   } state_t;

   localparam logic [1:0] C_BURST_INCR  = 2'b01;
   localparam logic [2:0] C_SIZE_4B     = 3'b010;
   localparam logic [1:0] C_RESP_OKAY   = 2'b00;
   localparam logic [1:0] C_RESP_SLVERR = 2'b10;

   function automatic int off_w(input int line_words);
      return $clog2(line_words * 4);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int line_words, input int sets);
      return 32 - off_w(line_words) - idx_w(sets);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24100006_icache_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24100006_icache_array : flop-based valid/tag/data line storage  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ysyx_24100006_icache_array
   import ysyx_24100006_icache_pkg::*;
#(
   parameter  int LINE_WORDS = 4,
   parameter  int SETS       = 16,
   localparam int IDX_W      = idx_w(SETS),
   localparam int TAG_W      = tag_w(LINE_WORDS, SETS),
   localparam int WRD_W      = off_w(LINE_WORDS) - 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_rd_en,
   input  logic [IDX_W-1:0] i_rd_idx,
   input  logic [WRD_W-1:0] i_rd_word,
   output logic             o_rd_valid,
   output logic [TAG_W-1:0] o_rd_tag,
   output logic [31:0]      o_rd_data,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [WRD_W-1:0] i_wr_word,
   input  logic [31:0]      i_wr_data,
   input  logic             i_set_en,
   input  logic [IDX_W-1:0] i_set_idx,
   input  logic [TAG_W-1:0] i_set_tag,
   input  logic             i_set_valid,
   input  logic             i_flush
);

   logic [SETS-1:0]  r_valid;
   logic [TAG_W-1:0] r_tag  [SETS];
   logic [31:0]      r_data [SETS][LINE_WORDS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid    <= '0;
         o_rd_valid <= 1'b0;
         o_rd_tag   <= '0;
         o_rd_data  <= '0;
      end else begin
         if (i_flush)
            r_valid <= '0;
         else if (i_set_en)
            r_valid[i_set_idx] <= i_set_valid;
         if (i_rd_en) begin
            o_rd_valid <= r_valid[i_rd_idx];
            o_rd_tag   <= r_tag[i_rd_idx];
            o_rd_data  <= r_data[i_rd_idx][i_rd_word];
         end
      end
   end

   // Tags and data need no reset: a line is only consulted through its valid bit.
   always_ff @(posedge clk) begin
      if (i_set_en)
         r_tag[i_set_idx] <= i_set_tag;
      if (i_wr_en)
         r_data[i_wr_idx][i_wr_word] <= i_wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_24100006_icache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24100006_icache : direct-mapped read-only I-cache, AXI refill   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ysyx_24100006_icache
   import ysyx_24100006_icache_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic        s_rvalid,
   input  logic        s_rready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic [31:0] m_araddr,
   output logic        m_arvalid,
   input  logic        m_arready,
   output logic [7:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   input  logic        m_rvalid,
   output logic        m_rready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rlast,
   input  logic        fence_i,
   output logic        flush_done,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(LINE_WORDS, SETS);
   localparam int WRD_W = OFF_W - 2;
   localparam logic [WRD_W-1:0] C_LAST_BEAT = WRD_W'(LINE_WORDS - 1);

   state_t           r_state;
   logic [31:0]      r_addr;
   logic [WRD_W-1:0] r_cnt;
   logic             r_err;
   logic             r_s_rvalid;
   logic [31:0]      r_s_rdata;
   logic [1:0]       r_s_rresp;
   logic             r_m_arvalid;
   logic             r_m_rready;
   logic             r_flush_done;
   logic [31:0]      r_hit_cnt;
   logic [31:0]      r_miss_cnt;

   logic             w_accept;
   logic [TAG_W-1:0] w_req_tag;
   logic [IDX_W-1:0] w_req_idx;
   logic [WRD_W-1:0] w_req_word;
   logic             w_arr_valid;
   logic [TAG_W-1:0] w_arr_tag;
   logic [31:0]      w_arr_data;
   logic             w_hit;
   logic             w_beat;
   logic             w_err_last;
   logic             w_set_en;
   logic             w_unused_addr;

   assign s_arready  = reset && (r_state == S_IDLE) && !fence_i;
   assign w_accept   = s_arvalid && s_arready;
   assign w_req_tag  = r_addr[31 -: TAG_W];
   assign w_req_idx  = r_addr[OFF_W +: IDX_W];
   assign w_req_word = r_addr[2 +: WRD_W];
   assign w_hit      = w_arr_valid && (w_arr_tag == w_req_tag);
   assign w_beat     = m_rvalid && r_m_rready;
   // A short or long burst is as untrustworthy as an error response.
   assign w_err_last = r_err || (m_rresp != C_RESP_OKAY) || (r_cnt != C_LAST_BEAT);
   assign w_set_en   = ((r_state == S_LOOKUP) && !w_hit) ||
                       ((r_state == S_MISS_R) && w_beat && m_rlast && !w_err_last);
   assign w_unused_addr = ^r_addr[1:0];

   assign s_rvalid   = r_s_rvalid;
   assign s_rdata    = r_s_rdata;
   assign s_rresp    = r_s_rresp;
   assign m_araddr   = {w_req_tag, w_req_idx, {OFF_W{1'b0}}};
   assign m_arvalid  = r_m_arvalid;
   assign m_arlen    = 8'(LINE_WORDS - 1);
   assign m_arsize   = C_SIZE_4B;
   assign m_arburst  = C_BURST_INCR;
   assign m_rready   = r_m_rready;
   assign flush_done = r_flush_done;
   assign hit_cnt    = r_hit_cnt;
   assign miss_cnt   = r_miss_cnt;

   // A miss drops the line's valid bit up front so a partial refill is never hit.
   ysyx_24100006_icache_array #(
      .LINE_WORDS (LINE_WORDS),
      .SETS       (SETS)
   ) u_array (
      .clk         (clk),
      .reset       (reset),
      .i_rd_en     (w_accept),
      .i_rd_idx    (s_araddr[OFF_W +: IDX_W]),
      .i_rd_word   (s_araddr[2 +: WRD_W]),
      .o_rd_valid  (w_arr_valid),
      .o_rd_tag    (w_arr_tag),
      .o_rd_data   (w_arr_data),
      .i_wr_en     ((r_state == S_MISS_R) && w_beat),
      .i_wr_idx    (w_req_idx),
      .i_wr_word   (r_cnt),
      .i_wr_data   (m_rdata),
      .i_set_en    (w_set_en),
      .i_set_idx   (w_req_idx),
      .i_set_tag   (w_req_tag),
      .i_set_valid (r_state == S_MISS_R),
      .i_flush     (r_state == S_FLUSH)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_err        <= 1'b0;
         r_s_rvalid   <= 1'b0;
         r_s_rdata    <= '0;
         r_s_rresp    <= C_RESP_OKAY;
         r_m_arvalid  <= 1'b0;
         r_m_rready   <= 1'b0;
         r_flush_done <= 1'b0;
         r_hit_cnt    <= '0;
         r_miss_cnt   <= '0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (fence_i) begin
                  r_state <= S_FLUSH;
               end else if (s_arvalid) begin
                  r_addr  <= s_araddr;
                  r_state <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (w_hit) begin
                  r_s_rdata  <= w_arr_data;
                  r_s_rresp  <= C_RESP_OKAY;
                  r_s_rvalid <= 1'b1;
                  if (r_hit_cnt != '1)
                     r_hit_cnt <= r_hit_cnt + 32'd1;
                  r_state <= S_RESP;
               end else begin
                  if (r_miss_cnt != '1)
                     r_miss_cnt <= r_miss_cnt + 32'd1;
                  r_m_arvalid <= 1'b1;
                  r_state     <= S_MISS_AR;
               end
            end
            S_MISS_AR: begin
               if (m_arready) begin
                  r_m_arvalid <= 1'b0;
                  r_m_rready  <= 1'b1;
                  r_cnt       <= '0;
                  r_err       <= 1'b0;
                  r_state     <= S_MISS_R;
               end
            end
            S_MISS_R: begin
               if (w_beat) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (m_rresp != C_RESP_OKAY)
                     r_err <= 1'b1;
                  if (r_cnt == w_req_word)
                     r_s_rdata <= m_rdata;
                  if (m_rlast) begin
                     r_m_rready <= 1'b0;
                     r_s_rvalid <= 1'b1;
                     r_s_rresp  <= w_err_last ? C_RESP_SLVERR : C_RESP_OKAY;
                     r_state    <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (s_rready) begin
                  r_s_rvalid <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            S_FLUSH: begin
               r_flush_done <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_icache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_24100006_icache : directed bench with a behavioural cache    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ysyx_24100006_icache;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] s_araddr;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic [31:0] m_araddr;
   logic        m_arvalid, m_arready;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   logic        m_rvalid, m_rready, m_rlast;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        fence_i, flush_done;
   logic [31:0] hit_cnt, miss_cnt;

   ysyx_24100006_icache dut (
      .clk(clk), .reset(reset),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast),
      .fence_i(fence_i), .flush_done(flush_done),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_bad = 0;
   bit          chk_en = 1'b0;
   bit          chk_data = 1'b0;
   logic [31:0] exp_rdata;
   logic [1:0]  exp_rresp;
   logic [31:0] exp_hit = 32'd0;
   logic [31:0] exp_miss = 32'd0;
   bit          mv [16];
   logic [23:0] mt [16];
   logic [31:0] last_rdata;
   logic [1:0]  last_rresp;

   // Backing memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'hC0DE_5A00;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (m_arvalid) begin
            chk("m_arlen", {24'd0, m_arlen}, 32'd3);
            chk("m_arsize", {29'd0, m_arsize}, 32'd2);
            chk("m_arburst", {30'd0, m_arburst}, 32'd1);
         end
         if (s_rvalid) begin
            if (chk_data) chk("s_rdata", s_rdata, exp_rdata);
            chk("s_rresp", {30'd0, s_rresp}, {30'd0, exp_rresp});
            chk("hit_cnt", hit_cnt, exp_hit);
            chk("miss_cnt", miss_cnt, exp_miss);
         end
      end
   end

   task automatic fetch(input logic [31:0] addr, input int err_beat, input int aw, input int hold);
      logic [3:0]  idx;
      logic [23:0] tg;
      logic [31:0] line;
      bit          hit, err;
      int          t;
      idx  = addr[7:4];
      tg   = addr[31:8];
      line = {addr[31:4], 4'h0};
      hit  = mv[idx] && (mt[idx] == tg);
      err  = !hit && (err_beat >= 0);
      if (hit) exp_hit = exp_hit + 32'd1;
      else     exp_miss = exp_miss + 32'd1;
      exp_rdata = mem(addr);
      exp_rresp = err ? 2'b10 : 2'b00;
      chk_data  = !err;
      if (!hit) begin
         mv[idx] = !err;
         mt[idx] = tg;
      end
      s_araddr  = addr;
      s_arvalid = 1'b1;
      #1;
      t = 0;
      while (!s_arready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) begin
         chk1("arready_timeout", s_arready, 1'b1);
         s_arvalid = 1'b0;
         return;
      end
      @(negedge clk);
      s_arvalid = 1'b0;
      chk1("lookup_rvalid", s_rvalid, 1'b0);
      chk1("lookup_arvalid", m_arvalid, 1'b0);
      @(negedge clk);
      if (hit) begin
         chk1("hit_no_arvalid", m_arvalid, 1'b0);
      end else begin
         chk1("miss_arvalid", m_arvalid, 1'b1);
         chk("m_araddr", m_araddr, line);
         repeat (aw) begin
            @(negedge clk);
            chk1("arvalid_hold", m_arvalid, 1'b1);
            chk("araddr_hold", m_araddr, line);
         end
         m_arready = 1'b1;
         @(negedge clk);
         m_arready = 1'b0;
         chk1("arvalid_drop", m_arvalid, 1'b0);
         chk1("m_rready", m_rready, 1'b1);
         for (int i = 0; i < 4; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = mem(line + 32'(4 * i));
            m_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            m_rlast  = (i == 3);
            @(negedge clk);
         end
         m_rvalid = 1'b0;
         m_rlast  = 1'b0;
         m_rresp  = 2'b00;
         chk1("m_rready_drop", m_rready, 1'b0);
      end
      chk1("rvalid_latency", s_rvalid, 1'b1);
      last_rdata = s_rdata;
      last_rresp = s_rresp;
      repeat (hold) begin
         @(negedge clk);
         chk1("rvalid_hold", s_rvalid, 1'b1);
         chk("rdata_hold", s_rdata, last_rdata);
      end
      s_rready = 1'b1;
      @(negedge clk);
      s_rready = 1'b0;
      chk1("rvalid_drop", s_rvalid, 1'b0);
   endtask

   task automatic check_reset_outputs();
      chk1("rst_arready", s_arready, 1'b0);
      chk1("rst_rvalid", s_rvalid, 1'b0);
      chk("rst_rdata", s_rdata, 32'd0);
      chk("rst_rresp", {30'd0, s_rresp}, 32'd0);
      chk1("rst_arvalid", m_arvalid, 1'b0);
      chk1("rst_rready", m_rready, 1'b0);
      chk1("rst_flush_done", flush_done, 1'b0);
      chk("rst_hit_cnt", hit_cnt, 32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
      fence_i = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset = 1'b1;
      @(negedge clk);
      chk1("idle_arready", s_arready, 1'b1);
      chk_en = 1'b1;

      // Cold miss, hit after fill, conflict eviction
      fetch(32'h3000_0004, -1, 2, 0);
      chk("cold_rdata", last_rdata, 32'hF0DE_5A04);
      chk("cold_miss_cnt", miss_cnt, 32'd1);
      fetch(32'h3000_000C, -1, 0, 0);
      chk("hit_rdata", last_rdata, 32'hF0DE_5A0C);
      chk("hit_cnt_1", hit_cnt, 32'd1);
      fetch(32'h3000_0100, -1, 0, 0);
      fetch(32'h3000_0000, -1, 1, 0);
      chk("evict_miss_cnt", miss_cnt, 32'd3);

      // fence.i beats a simultaneous request
      fence_i = 1'b1; s_arvalid = 1'b1; s_araddr = 32'h3000_0004;
      #1;
      chk1("fence_arready", s_arready, 1'b0);
      @(negedge clk);
      s_arvalid = 1'b0;
      chk1("flush_done_early", flush_done, 1'b0);
      @(negedge clk);
      chk1("flush_done_pulse", flush_done, 1'b1);
      fence_i = 1'b0;
      @(negedge clk);
      chk1("flush_done_once", flush_done, 1'b0);
      model_clear();
      fetch(32'h3000_0004, -1, 0, 0);
      chk("post_fence_miss_cnt", miss_cnt, 32'd4);

      // Refill error, then clean refetch
      fetch(32'h3000_0024, 2, 0, 0);
      chk("err_rresp", {30'd0, last_rresp}, 32'd2);
      fetch(32'h3000_0024, -1, 0, 0);
      chk("refetch_rdata", last_rdata, 32'hF0DE_5A24);
      chk("refetch_miss_cnt", miss_cnt, 32'd6);

      // Backpressure on hit and miss, misaligned low bits
      fetch(32'h3000_0028, -1, 0, 5);
      chk("bp_hit_rdata", last_rdata, 32'hF0DE_5A28);
      chk("bp_hit_cnt", hit_cnt, 32'd2);
      fetch(32'h3000_0048, -1, 1, 3);
      fetch(32'h3000_004B, -1, 0, 0);
      chk("misaligned_rdata", last_rdata, 32'hF0DE_5A48);
      chk("misaligned_hit_cnt", hit_cnt, 32'd3);

      // Reset in the middle of a refill
      chk_en = 1'b0;
      s_araddr = 32'h3000_0080; s_arvalid = 1'b1;
      @(negedge clk);
      s_arvalid = 1'b0;
      @(negedge clk);
      chk1("abort_arvalid", m_arvalid, 1'b1);
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_rvalid = 1'b1;
         m_rdata  = mem(32'h3000_0080 + 32'(4 * i));
         @(negedge clk);
      end
      chk1("abort_in_refill", m_rready, 1'b1);
      m_rvalid = 1'b0;
      reset = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      exp_hit = 32'd0;
      exp_miss = 32'd0;
      @(negedge clk);
      chk_en = 1'b1;
      fetch(32'h3000_0080, -1, 0, 0);
      fetch(32'h3000_000C, -1, 0, 0);
      chk("post_reset_miss_cnt", miss_cnt, 32'd2);
      chk("post_reset_hit_cnt", hit_cnt, 32'd0);
      chk("post_reset_rdata", last_rdata, 32'hF0DE_5A0C);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ysyx_24100006_icache.md
Name: ysyx_24100006_icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU's AXI-Lite read master (upstream) and the memory-side AXI4 burst read port (downstream).
- Serves hits in 1 cycle. Refills whole lines on a miss using an INCR burst.
- Invalidates all lines on fence.i and pulses flush_done back to the IFU.

Parameters:
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2).
- SETS, 16, number of lines (power of 2).
- Derived constants: OFF_W=log2(LINE_WORDS*4), IDX_W=log2(SETS), TAG_W=32-OFF_W-IDX_W.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserts immediately when 0, released synchronously to clk).
- s_araddr  in  32  fetch address from IFU; word aligned.
- s_arvalid  in  1  fetch request valid.
- s_arready  out  1  cache accepts request.
- s_rvalid  out  1  instruction valid.
- s_rready  in  1  IFU accepts instruction.
- s_rdata  out  32  instruction word.
- s_rresp  out  2  0=OKAY, 2=SLVERR propagated from refill.
- m_araddr  out  32  line-aligned refill address.
- m_arvalid  out  1.
- m_arready  in  1.
- m_arlen  out  8  LINE_WORDS-1.
- m_arsize  out  3  constant 3'b010.
- m_arburst  out  2  constant 2'b01 (INCR).
- m_rvalid  in  1.
- m_rready  out  1.
- m_rdata  in  32.
- m_rresp  in  2.
- m_rlast  in  1.
- fence_i  in  1  level request to invalidate the whole cache.
- flush_done  out  1  one-cycle pulse when invalidation completes.
- hit_cnt  out  32  saturating hit counter.
- miss_cnt  out  32  saturating miss counter.

Behaviour:
- Storage: valid[SETS], tag[SETS][TAG_W], data[SETS][LINE_WORDS][32], all flops.
- Reset (reset=0):
  - state=IDLE; all valid bits cleared.
  - s_arready=0, s_rvalid=0, s_rdata=0, s_rresp=0, m_arvalid=0, m_rready=0, flush_done=0, counters=0.
  - An in-flight refill is abandoned with no line marked valid.
- States: IDLE, LOOKUP, MISS_AR, MISS_R, RESP, FLUSH.
- IDLE:
  - s_arready = 1 iff state==IDLE and fence_i==0 (combinational).
  - On a fence_i=1 cycle, enter FLUSH; fence_i wins over a simultaneous s_arvalid, and the request is not accepted.
  - On an s_arvalid&s_arready handshake, latch the address and enter LOOKUP.
- LOOKUP (1 cycle):
  - Hit (valid[idx] && tag match): load s_rdata from data[idx][word], s_rresp=0, s_rvalid=1, hit_cnt++, go to RESP.
  - Miss: miss_cnt++, m_arvalid=1, m_araddr={tag,idx,OFF_W'0}, go to MISS_AR.
- MISS_AR: hold m_arvalid and address stable until m_arready. Then m_arvalid=0, m_rready=1, beat counter=0, go to MISS_R.
- MISS_R:
  - Each m_rvalid beat writes data[idx][cnt] and increments cnt (wraps modulo LINE_WORDS).
  - Any beat with m_rresp≠0 sets a sticky err flag.
  - On the m_rlast beat:
    - m_rready=0.
    - err=0: set valid[idx], write tag, s_rdata=requested word (take it from m_rdata if it arrives in the last beat), s_rresp=0.
    - err=1: leave valid[idx]=0, s_rresp=2'b10.
    - s_rvalid=1, go to RESP.
  - m_rlast on a beat count other than LINE_WORDS-1 is treated as an error.
- RESP: hold s_rvalid/s_rdata until s_rready. Then s_rvalid=0 and return to IDLE. s_rvalid never deasserts without a handshake.
- FLUSH (1 cycle): clear all valid bits; next cycle flush_done=1 for exactly one cycle; return to IDLE.
  - fence_i that arrives during LOOKUP/MISS_*/RESP stays pending and is honoured on return to IDLE; the current fetch completes first.
  - fence_i held high after flush_done triggers another flush. The requester must drop fence_i on flush_done.
- Latency:
  - Hit: request handshake at cycle N, s_rvalid at N+2 (LOOKUP at N+1).
  - Miss: N+2+arready wait+LINE_WORDS beats+1.
- Counters saturate at 32'hFFFF_FFFF. Only reset clears them; flushes do not.
- Misaligned s_araddr[1:0]: the low bits are ignored. The IFU raises its own fault.

Decomposition:
- Package ysyx_24100006_icache_pkg: state encoding enum, AXI burst/size/resp constants, and the OFF_W/IDX_W/TAG_W functions.
- Sub-module ysyx_24100006_icache_array: valid/tag/data storage with a 1-cycle read port, a word-write port for refill, a tag+valid set port, and a flush-all port.

Test Plan:
- Cold miss:
  - Stimulus: fetch 0x3000_0004 with memory returning 4 beats A0..A3.
  - Response: m_araddr=0x3000_0000, m_arlen=3; s_rdata=A1, s_rresp=0; miss_cnt=1.
- Hit after fill:
  - Stimulus: fetch 0x3000_000C.
  - Response: s_rvalid 2 cycles after the handshake, s_rdata=A3, no m_arvalid; hit_cnt=1.
- Conflict eviction:
  - Stimulus: fetch 0x3000_0100 (same index, new tag), then 0x3000_0000.
  - Response: both miss and each issues a burst; miss_cnt=3.
- fence.i:
  - Stimulus: assert fence_i together with s_arvalid in IDLE.
  - Response: s_arready=0 that cycle, then a flush_done pulse 2 cycles later; the next fetch of 0x3000_0004 misses.
- Refill error:
  - Stimulus: beat 2 carries m_rresp=2.
  - Response: s_rresp=2; a re-fetch of the same address misses again.
- Backpressure and reset:
  - Stimulus: hold s_rready=0 for 5 cycles; separately, pull reset low mid-MISS_R.
  - Response: s_rvalid and s_rdata stay stable until the handshake; after reset the line is invalid and all outputs are at their reset values.
